// File: rtl/ucisc_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, step codes,
// instruction field positions and condition codes.
package ucisc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    localparam logic [1:0] STEP_FETCH     = 2'd0;
    localparam logic [1:0] STEP_DECODE    = 2'd1;
    localparam logic [1:0] STEP_EXECUTE   = 2'd2;
    localparam logic [1:0] STEP_WRITEBACK = 2'd3;

    // Instruction word layout
    localparam int SRC_LO    = 0;
    localparam int SRC_HI    = 3;
    localparam int DST_LO    = 4;
    localparam int DST_HI    = 7;
    localparam int ALU_LO    = 8;
    localparam int ALU_HI    = 11;
    localparam int STACK_BIT = 12;
    localparam int FLAGS_BIT = 13;
    localparam int COND_LO   = 14;
    localparam int COND_HI   = 15;

    localparam int FLAG_ZERO_BIT = 0;
    localparam int FLAG_NEG_BIT  = 1;

    localparam logic [1:0] COND_ALWAYS   = 2'b00;
    localparam logic [1:0] COND_ZERO     = 2'b01;
    localparam logic [1:0] COND_NOT_ZERO = 2'b10;
    localparam logic [1:0] COND_NEG      = 2'b11;

    localparam logic [15:0] HALT_WORD = 16'h0000;
    localparam logic [3:0]  PC_REG    = 4'd0;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Bundle of the sequencer's memory handshake, status inputs and register-block
// controls. master = sequencer side, slave = memory/register-block side.
interface instruction_sequencer_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] flags;
    logic        mem_wait;
    logic [1:0]  step;
    logic [3:0]  desired_source;
    logic [3:0]  desired_destination;
    logic [3:0]  alu_op;
    logic        write_enable;
    logic        write_flags;
    logic        push;
    logic        pop;
    logic        inc_enable;
    logic        halted;

    modport master (
        input  instr, instr_valid, flags, mem_wait,
        output instr_ready, step, desired_source, desired_destination, alu_op,
               write_enable, write_flags, push, pop, inc_enable, halted
    );

    modport slave (
        output instr, instr_valid, flags, mem_wait,
        input  instr_ready, step, desired_source, desired_destination, alu_op,
               write_enable, write_flags, push, pop, inc_enable, halted
    );
endinterface

// File: rtl/condition_check.sv
// Combinational evaluation of an instruction's 2-bit condition against the
// zero/negative flags.
module condition_check
    import ucisc_pkg::*;
(
    input  logic [1:0] cond,
    input  logic [1:0] flags,
    output logic       pass
);

    // Condition code decode
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_ALWAYS:   pass = 1'b1;
            COND_ZERO:     pass = flags[FLAG_ZERO_BIT];
            COND_NOT_ZERO: pass = ~flags[FLAG_ZERO_BIT];
            COND_NEG:      pass = flags[FLAG_NEG_BIT];
            default:       pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Four-step FETCH/DECODE/EXECUTE/WRITEBACK sequencer with conditional execution,
// stack strobes, data-memory wait and a terminal HALT on instruction 0x0000.
module instruction_sequencer
    import ucisc_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    instruction_sequencer_if.master bus
);

    state_t      state_r;
    logic [15:0] instr_r;
    logic [1:0]  step_r;
    logic        execute_ok_r;
    logic        instr_ready_r;
    logic        halted_r;
    logic        write_enable_r;
    logic        write_flags_r;
    logic        push_r;
    logic        inc_enable_r;
    logic        pass_s;
    logic        pop_s;
    logic        unused_flags_s;

    condition_check u_condition_check (
        .cond  (instr_r[COND_HI:COND_LO]),
        .flags (bus.flags[FLAG_NEG_BIT:FLAG_ZERO_BIT]),
        .pass  (pass_s)
    );

    // Pop follows the live condition so the stack is read during DECODE itself
    always_comb begin
        pop_s = 1'b0;
        if (state_r == ST_DECODE) begin
            pop_s = instr_r[STACK_BIT] & pass_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Sequencer state machine; write-phase strobes default low every cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_FETCH;
            instr_r        <= 16'h0000;
            step_r         <= STEP_FETCH;
            execute_ok_r   <= 1'b0;
            instr_ready_r  <= 1'b0;
            halted_r       <= 1'b0;
            write_enable_r <= 1'b0;
            write_flags_r  <= 1'b0;
            push_r         <= 1'b0;
            inc_enable_r   <= 1'b0;
        end else begin
            write_enable_r <= 1'b0;
            write_flags_r  <= 1'b0;
            push_r         <= 1'b0;
            inc_enable_r   <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    if (bus.instr_valid && instr_ready_r) begin
                        instr_r       <= bus.instr;
                        state_r       <= ST_DECODE;
                        step_r        <= STEP_DECODE;
                        instr_ready_r <= 1'b0;
                    end else begin
                        instr_ready_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    execute_ok_r <= pass_s;
                    state_r      <= ST_EXECUTE;
                    step_r       <= STEP_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (!bus.mem_wait) begin
                        state_r        <= ST_WRITEBACK;
                        step_r         <= STEP_WRITEBACK;
                        write_enable_r <= execute_ok_r;
                        write_flags_r  <= execute_ok_r & instr_r[FLAGS_BIT];
                        push_r         <= execute_ok_r & instr_r[STACK_BIT];
                        // A taken write to the PC replaces the increment
                        inc_enable_r   <= ~(execute_ok_r && (instr_r[DST_HI:DST_LO] == PC_REG));
                    end else begin
                        state_r <= ST_EXECUTE;
                    end
                end
                ST_WRITEBACK: begin
                    if (instr_r == HALT_WORD) begin
                        state_r  <= ST_HALT;
                        step_r   <= STEP_WRITEBACK;
                        halted_r <= 1'b1;
                    end else begin
                        state_r       <= ST_FETCH;
                        step_r        <= STEP_FETCH;
                        instr_ready_r <= 1'b1;
                    end
                end
                ST_HALT: begin
                    step_r        <= STEP_WRITEBACK;
                    halted_r      <= 1'b1;
                    instr_ready_r <= 1'b0;
                end
                default: begin
                    state_r       <= ST_FETCH;
                    step_r        <= STEP_FETCH;
                    instr_ready_r <= 1'b0;
                    halted_r      <= 1'b0;
                end
            endcase
        end
    end

    assign unused_flags_s          = ^bus.flags[15:2];
    assign bus.instr_ready         = instr_ready_r;
    assign bus.step                = step_r;
    assign bus.desired_source      = instr_r[SRC_HI:SRC_LO];
    assign bus.desired_destination = instr_r[DST_HI:DST_LO];
    assign bus.alu_op              = instr_r[ALU_HI:ALU_LO];
    assign bus.write_enable        = write_enable_r;
    assign bus.write_flags         = write_flags_r;
    assign bus.push                = push_r;
    assign bus.pop                 = pop_s;
    assign bus.inc_enable          = inc_enable_r;
    assign bus.halted              = halted_r;

endmodule
